// File: rtl/dist_filter_if.sv
// Bus between the range-sensor stage, the distance filter and the BCD stage.
// The filter is the slave; whoever drives samples and watches results is the master.
interface dist_filter_if;
    logic        synch;
    logic [11:0] distance_in;
    logic [11:0] dist_out;
    logic        synch_out;
    logic        err;
    logic [7:0]  drop_cnt;

    modport master (
        output synch,
        output distance_in,
        input  dist_out,
        input  synch_out,
        input  err,
        input  drop_cnt
    );

    modport slave (
        input  synch,
        input  distance_in,
        output dist_out,
        output synch_out,
        output err,
        output drop_cnt
    );
endinterface

// File: rtl/dist_filter.sv
// Distance filter: 3-tap median over valid samples followed by a 4-tap moving
// average. Invalid codes (0 or above MAX_DIST) are kept out of the filter but
// still produce an output pulse, and a run of them raises err.
module dist_filter #(
    parameter int MAX_DIST  = 400,
    parameter int ERR_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    dist_filter_if.slave bus
);

    localparam int               CNT_W     = $clog2(ERR_LIMIT + 1);
    localparam logic [CNT_W-1:0] ERR_LIM_C = CNT_W'(ERR_LIMIT);
    localparam logic [11:0]      MAX_C     = 12'(MAX_DIST);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SORT1 = 3'd1,
        SORT2 = 3'd2,
        SORT3 = 3'd3,
        AVG   = 3'd4,
        OUT   = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_next_s;

    logic [11:0]      win_r   [3];
    logic [11:0]      win_next_s [3];
    logic [11:0]      srt_r   [3];
    logic [11:0]      hist_r  [4];
    logic [13:0]      sum_r;
    logic             first_r;
    logic             valid_r;
    logic [CNT_W-1:0] inv_cnt_r;
    logic [CNT_W-1:0] inv_next_s;

    logic [11:0]      dist_out_r;
    logic             synch_out_r;
    logic             err_r;
    logic [7:0]       drop_cnt_r;

    logic             sample_valid_s;

    assign sample_valid_s = (bus.distance_in >= 12'd1) && (bus.distance_in <= MAX_C);

    assign bus.dist_out  = dist_out_r;
    assign bus.synch_out = synch_out_r;
    assign bus.err       = err_r;
    assign bus.drop_cnt  = drop_cnt_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: only IDLE waits for a sample, the rest is a fixed pipeline walk.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (bus.synch) begin
                    state_next_s = SORT1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SORT1:   state_next_s = SORT2;
            SORT2:   state_next_s = SORT3;
            SORT3:   state_next_s = AVG;
            AVG:     state_next_s = OUT;
            OUT:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Window contents after accepting distance_in; a first sample floods every tap.
    always_comb begin
        win_next_s[0] = win_r[1];
        win_next_s[1] = win_r[2];
        win_next_s[2] = bus.distance_in;
        if (first_r) begin
            win_next_s[0] = bus.distance_in;
            win_next_s[1] = bus.distance_in;
        end else begin
            win_next_s[0] = win_r[1];
            win_next_s[1] = win_r[2];
        end
    end

    // Consecutive-invalid count as it will be after the sample now in flight.
    always_comb begin
        inv_next_s = inv_cnt_r;
        if (valid_r) begin
            inv_next_s = {CNT_W{1'b0}};
        end else if (inv_cnt_r == ERR_LIM_C) begin
            inv_next_s = inv_cnt_r;
        end else begin
            inv_next_s = inv_cnt_r + CNT_W'(1);
        end
    end

    // Filter datapath: window capture, three-step median sort, history/sum update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                win_r[i] <= 12'd0;
                srt_r[i] <= 12'd0;
            end
            for (int i = 0; i < 4; i++) begin
                hist_r[i] <= 12'd0;
            end
            sum_r   <= 14'd0;
            first_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.synch) begin
                        valid_r <= sample_valid_s;
                        if (sample_valid_s) begin
                            for (int i = 0; i < 3; i++) begin
                                win_r[i] <= win_next_s[i];
                                srt_r[i] <= win_next_s[i];
                            end
                            if (first_r) begin
                                for (int i = 0; i < 4; i++) begin
                                    hist_r[i] <= bus.distance_in;
                                end
                                sum_r   <= {bus.distance_in, 2'b00};
                                first_r <= 1'b0;
                            end
                        end
                    end
                end
                SORT1, SORT3: begin
                    if (srt_r[0] > srt_r[1]) begin
                        srt_r[0] <= srt_r[1];
                        srt_r[1] <= srt_r[0];
                    end
                end
                SORT2: begin
                    if (srt_r[1] > srt_r[2]) begin
                        srt_r[1] <= srt_r[2];
                        srt_r[2] <= srt_r[1];
                    end
                end
                AVG: begin
                    if (valid_r) begin
                        hist_r[0] <= hist_r[1];
                        hist_r[1] <= hist_r[2];
                        hist_r[2] <= hist_r[3];
                        hist_r[3] <= srt_r[1];
                        sum_r     <= sum_r - {2'b00, hist_r[0]} + {2'b00, srt_r[1]};
                    end
                end
                OUT: begin
                    valid_r <= valid_r;
                end
                default: begin
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered outputs: result, strobe and error flag update together in OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dist_out_r  <= 12'd0;
            synch_out_r <= 1'b0;
            err_r       <= 1'b0;
            inv_cnt_r   <= {CNT_W{1'b0}};
        end else if (state_r == OUT) begin
            dist_out_r  <= sum_r[13:2];
            synch_out_r <= 1'b1;
            inv_cnt_r   <= inv_next_s;
            err_r       <= (inv_next_s == ERR_LIM_C);
        end else begin
            synch_out_r <= 1'b0;
        end
    end

    // Count sensor pulses that arrive while a sample is still being filtered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r <= 8'd0;
        end else if (bus.synch && (state_r != IDLE) && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

endmodule
